// File: rtl/i2c_bus_arbiter_if.sv
// Client/master-side bus bundle for i2c_bus_arbiter.
// The master modport is the arbiter's view; slave is the surrounding clients and I2C master.
interface i2c_bus_arbiter_if #(
  parameter int unsigned NREQ = 2
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_rw;
  logic [7*NREQ-1:0]  req_dev;
  logic [8*NREQ-1:0]  req_sub;
  logic [NREQ-1:0]    req_len;
  logic [16*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [15:0]        rdata;
  logic               nack;
  logic               timeout;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_rw;
  logic [6:0]         cmd_dev;
  logic [7:0]         cmd_sub;
  logic               cmd_len;
  logic [15:0]        cmd_wdata;
  logic               rsp_valid;
  logic [15:0]        rsp_data;
  logic               rsp_nack;
  logic               cmd_abort;

  modport master (
    input  req, req_rw, req_dev, req_sub, req_len, req_wdata,
    output grant, done, rdata, nack, timeout,
    output cmd_valid, cmd_rw, cmd_dev, cmd_sub, cmd_len, cmd_wdata, cmd_abort,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

  modport slave (
    output req, req_rw, req_dev, req_sub, req_len, req_wdata,
    input  grant, done, rdata, nack, timeout,
    input  cmd_valid, cmd_rw, cmd_dev, cmd_sub, cmd_len, cmd_wdata, cmd_abort,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one I2C master command port between NREQ requesters.
// Optional transaction watchdog compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic               clk,
  input  logic               reset,
  i2c_bus_arbiter_if.master  bus
);

  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("i2c_bus_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ABORT,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] done_r;
  logic [15:0]     rdata_r;
  logic            nack_r;
  logic            timeout_r;
  logic            cmd_valid_r;
  logic            cmd_rw_r;
  logic [6:0]      cmd_dev_r;
  logic [7:0]      cmd_sub_r;
  logic            cmd_len_r;
  logic [15:0]     cmd_wdata_r;
  logic            abort_r;
  logic            expired;

  // Round-robin pick: first set request scanning up from last+1.
  logic            win_found;
  logic [IW-1:0]   win_idx;
  int              win_sel;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!win_found && bus.req[(int'(last) + k) % int'(NREQ)]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last) + k) % int'(NREQ));
      end
    end
    win_sel = int'(win_idx);
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wd_cnt;

  // Per-transaction cycle counter, zero whenever no transaction is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE || state == S_WAIT) begin
      wd_cnt <= wd_cnt + CW'(1);
    end else if (state == S_IDLE) begin
      wd_cnt <= '0;
    end
  end

  assign expired = (state == S_ISSUE || state == S_WAIT) &&
                   (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last        <= IW'(NREQ - 1);
      grant_r     <= '0;
      done_r      <= '0;
      rdata_r     <= '0;
      nack_r      <= 1'b0;
      timeout_r   <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_rw_r    <= 1'b0;
      cmd_dev_r   <= '0;
      cmd_sub_r   <= '0;
      cmd_len_r   <= 1'b0;
      cmd_wdata_r <= '0;
      abort_r     <= 1'b0;
    end else begin
      done_r  <= '0;
      abort_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_r     <= NREQ'(1) << win_idx;
            last        <= win_idx;
            cmd_rw_r    <= bus.req_rw[win_sel];
            cmd_dev_r   <= bus.req_dev[7*win_sel +: 7];
            cmd_sub_r   <= bus.req_sub[8*win_sel +: 8];
            cmd_len_r   <= bus.req_len[win_sel];
            cmd_wdata_r <= bus.req_wdata[16*win_sel +: 16];
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (expired) begin
            cmd_valid_r <= 1'b0;
            abort_r     <= 1'b1;
            nack_r      <= 1'b1;
            timeout_r   <= 1'b1;
            state       <= S_ABORT;
          end else if (!cmd_valid_r) begin
            cmd_valid_r <= 1'b1;
          end else if (bus.cmd_ready) begin
            cmd_valid_r <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the expiry cycle takes priority over the abort.
          if (bus.rsp_valid) begin
            if (cmd_rw_r) begin
              rdata_r <= cmd_len_r ? bus.rsp_data : {8'h00, bus.rsp_data[7:0]};
            end
            nack_r    <= bus.rsp_nack;
            timeout_r <= 1'b0;
            done_r    <= grant_r;
            state     <= S_DONE;
          end else if (expired) begin
            abort_r   <= 1'b1;
            nack_r    <= 1'b1;
            timeout_r <= 1'b1;
            state     <= S_ABORT;
          end
        end
        S_ABORT: begin
          done_r <= grant_r;
          state  <= S_DONE;
        end
        S_DONE: begin
          grant_r <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.rdata     = rdata_r;
  assign bus.nack      = nack_r;
  assign bus.timeout   = timeout_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_rw    = cmd_rw_r;
  assign bus.cmd_dev   = cmd_dev_r;
  assign bus.cmd_sub   = cmd_sub_r;
  assign bus.cmd_len   = cmd_len_r;
  assign bus.cmd_wdata = cmd_wdata_r;
  assign bus.cmd_abort = abort_r;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter (NREQ=2, TIMEOUT_CYCLES=16).
// Watchdog checks follow whether I2C_ARB_TIMEOUT_EN is defined for the build.
module tb_i2c_bus_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TO   = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_bus_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.cmd_valid), 1);
  endtask

  // Accept the pending command, respond one cycle later, end in the done cycle.
  task automatic serve(input string tag, input logic [15:0] d, input logic nk,
                       input logic [1:0] g);
    wait_valid({tag, "_valid"});
    check({tag, "_grant"}, 32'(bus.grant), 32'(g));
    bus.cmd_ready = 1'b1;
    tick();
    check({tag, "_accept"}, 32'(bus.cmd_valid), 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = d;
    bus.rsp_nack  = nk;
    tick();
    bus.rsp_valid = 1'b0;
    bus.rsp_nack  = 1'b0;
    check({tag, "_done"}, 32'(bus.done), 32'(g));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int          cnt;
    int          ab;
    logic [1:0]  exp_g;
    logic [15:0] exp_w;

    reset         = 1'b0;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_dev   = '0;
    bus.req_sub   = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_nack  = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_nack", 32'(bus.nack), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd_dev", 32'(bus.cmd_dev), 0);
    check("rst_cmd_abort", 32'(bus.cmd_abort), 0);
    reset = 1'b1;
    tick();

    // Single one-byte read from requester 0
    bus.req_rw    = 2'b11;
    bus.req_dev   = {7'h50, 7'h4B};
    bus.req_sub   = {8'h20, 8'h0B};
    bus.req_len   = 2'b10;
    bus.cmd_ready = 1'b1;
    bus.req       = 2'b01;
    tick();
    check("rd_grant_early", 32'(bus.grant), 32'h1);
    check("rd_cmd_dev", 32'(bus.cmd_dev), 32'h4B);
    check("rd_cmd_sub", 32'(bus.cmd_sub), 32'h0B);
    check("rd_cmd_rw", 32'(bus.cmd_rw), 1);
    check("rd_cmd_len", 32'(bus.cmd_len), 0);
    check("rd_valid_late", 32'(bus.cmd_valid), 0);
    serve("rd", 16'hABCB, 1'b0, 2'b01);
    check("rd_rdata", 32'(bus.rdata), 32'h00CB);
    check("rd_nack", 32'(bus.nack), 0);
    bus.req = 2'b00;
    tick();
    check("rd_done_pulse", 32'(bus.done), 0);
    check("rd_grant_clr", 32'(bus.grant), 0);

    // Two-byte read from requester 1, NACKed
    bus.req = 2'b10;
    serve("nack", 16'h1234, 1'b1, 2'b10);
    check("nack_nack", 32'(bus.nack), 1);
    check("nack_rdata", 32'(bus.rdata), 32'h1234);
    check("nack_timeout", 32'(bus.timeout), 0);
    check("nack_cmd_dev", 32'(bus.cmd_dev), 32'h50);
    bus.req = 2'b00;
    tick();

    // Round-robin writes with both requesting; rdata must not change
    bus.req_rw    = 2'b00;
    bus.req_wdata = {16'h2222, 16'h1111};
    bus.req       = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_w = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      serve("rr", 16'h5A5A, 1'b0, exp_g);
      check("rr_wdata", 32'(bus.cmd_wdata), 32'(exp_w));
      check("rr_rdata_kept", 32'(bus.rdata), 32'h1234);
      check("rr_nack", 32'(bus.nack), 0);
    end
    bus.req = 2'b00;
    tick();

    // Backpressure: cmd_ready low for 5 cycles of cmd_valid
    bus.cmd_ready = 1'b0;
    bus.req_len   = 2'b01;
    bus.req_wdata = {16'h2222, 16'hBEEF};
    bus.req       = 2'b01;
    wait_valid("bp_valid_rise");
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.cmd_valid), 1);
      check("bp_wdata", 32'(bus.cmd_wdata), 32'hBEEF);
      check("bp_dev", 32'(bus.cmd_dev), 32'h4B);
      check("bp_len", 32'(bus.cmd_len), 1);
      check("bp_grant", 32'(bus.grant), 32'h1);
      if (i < 4) tick();
    end
    bus.cmd_ready = 1'b1;
    tick();
    check("bp_accept", 32'(bus.cmd_valid), 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 16'h0F0F;
    tick();
    bus.rsp_valid = 1'b0;
    check("bp_done", 32'(bus.done), 32'h1);
    check("bp_rdata_kept", 32'(bus.rdata), 32'h1234);
    bus.req = 2'b00;
    tick();

    // Master never answers
    bus.req = 2'b01;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt = 0;
    while (bus.grant == 2'b00 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("wd_granted", 32'(bus.grant), 32'h1);
    cnt = 0;
    while (bus.cmd_abort !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("wd_abort_delay", 32'(cnt), 16);
    check("wd_abort_valid", 32'(bus.cmd_valid), 0);
    check("wd_abort_nack", 32'(bus.nack), 1);
    check("wd_abort_timeout", 32'(bus.timeout), 1);
    check("wd_abort_no_done", 32'(bus.done), 0);
    tick();
    check("wd_done", 32'(bus.done), 32'h1);
    check("wd_abort_pulse", 32'(bus.cmd_abort), 0);
    check("wd_nack", 32'(bus.nack), 1);
    check("wd_timeout", 32'(bus.timeout), 1);
    check("wd_rdata_kept", 32'(bus.rdata), 32'h1234);
    tick();
    check("wd_done_pulse", 32'(bus.done), 0);
    wait_valid("wd_reissue");
    tick();
`else
    cnt = 0;
    ab  = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.done != 2'b00) cnt++;
      if (bus.cmd_abort) ab++;
    end
    check("nowd_no_done", 32'(cnt), 0);
    check("nowd_no_abort", 32'(ab), 0);
    check("nowd_timeout", 32'(bus.timeout), 0);
    check("nowd_grant_held", 32'(bus.grant), 32'h1);
`endif

    // Asynchronous reset while waiting for a response
    check("prerst_grant", 32'(bus.grant), 32'h1);
    reset   = 1'b0;
    bus.req = 2'b11;
    #2;
    check("arst_grant", 32'(bus.grant), 0);
    check("arst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("arst_rdata", 32'(bus.rdata), 0);
    check("arst_nack", 32'(bus.nack), 0);
    check("arst_cmd_dev", 32'(bus.cmd_dev), 0);
    check("arst_done", 32'(bus.done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("post_rst_grant", 32'(bus.grant), 32'h1);
    serve("post_rst", 16'h0077, 1'b0, 2'b01);
    check("post_rst_nack", 32'(bus.nack), 0);
    bus.req = 2'b00;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
